// File: rtl/idb_source_sequencer_pkg.sv
// Shared definitions for the internal-data-bus source sequencer.
// Holds the FSM state encoding, bus select widths, the idle select
// constant and the source-index to one-hot select decode.
package idb_source_sequencer_pkg;

    localparam int IDB_SRC_W  = 3;
    localparam int IDB_CNTL_W = 9;

    localparam logic [IDB_CNTL_W-1:0] IDB_CNTL_IDLE = 9'h000;

    typedef enum logic [1:0] {
        IDB_SEQ_IDLE = 2'd0,
        IDB_SEQ_RUN  = 2'd1,
        IDB_SEQ_DONE = 2'd2
    } idb_seq_state_e;

    // Source 0..7 maps to bits 7:0; bit 8 of the mux select is never used,
    // so the mux priority encoder only ever sees a single set bit.
    function automatic logic [IDB_CNTL_W-1:0] idb_src_onehot(input logic [IDB_SRC_W-1:0] src);
        return IDB_CNTL_W'(1) << src;
    endfunction

endpackage

// File: rtl/idb_source_sequencer_step_ram.sv
// idb_step_ram: program step store, DEPTH entries of W bits.
// Synchronous write, asynchronous read. Reset clears every entry so the
// last flags start out cleared.
//   clk, rst_n       : clock, synchronous active-low reset
//   wr_en/addr/data  : step write port
//   rd_addr/rd_data  : combinational read port (playback pointer)
module idb_step_ram #(
    parameter int DEPTH = 8,
    parameter int W     = 10,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/idb_source_sequencer.sv
// idb_source_sequencer: plays a stored program of internal-data-bus
// transfers, one step per cycle, driving the bus mux select (cntl) and the
// destination latch strobes (dst_ld). rdy=0 stalls playback.
//   clk, rst_n                 : clock, synchronous active-low reset
//   ld_valid/ld_ready          : step load handshake
//   ld_src/ld_dst/ld_last      : step contents
//   clear                      : empty program (IDLE only)
//   go                         : start playback (IDLE only)
//   rdy                        : core RDY, 0 stalls
//   cntl                       : one-hot mux select, 0 when not running
//   dst_ld                     : destination strobes, gated by rdy
//   busy, done, count          : status
module idb_source_sequencer
    import idb_source_sequencer_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int DST_W = 6,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [IDB_SRC_W-1:0]  ld_src,
    input  logic [DST_W-1:0]      ld_dst,
    input  logic                  ld_last,
    input  logic                  clear,
    input  logic                  go,
    input  logic                  rdy,
    output logic [IDB_CNTL_W-1:0] cntl,
    output logic [DST_W-1:0]      dst_ld,
    output logic                  busy,
    output logic                  done,
    output logic [CW-1:0]         count
);

    localparam int SW = IDB_SRC_W + DST_W + 1;

    idb_seq_state_e       state;
    logic [AW-1:0]        ptr;
    logic [SW-1:0]        step;
    logic [IDB_SRC_W-1:0] step_src;
    logic [DST_W-1:0]     step_dst;
    logic                 step_last;
    logic                 wr_en;
    logic                 terminal;

    assign ld_ready = (state == IDB_SEQ_IDLE) && (count < CW'(DEPTH));
    // clear beats a simultaneous write; ld_ready already implies IDLE
    assign wr_en    = ld_valid && ld_ready && !clear;

    idb_step_ram #(.DEPTH(DEPTH), .W(SW)) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (count[AW-1:0]),
        .wr_data ({ld_src, ld_dst, ld_last}),
        .rd_addr (ptr),
        .rd_data (step)
    );

    assign step_src  = step[SW-1 -: IDB_SRC_W];
    assign step_dst  = step[DST_W:1];
    assign step_last = step[0];

    // A program without any last flag ends on its final stored step.
    assign terminal = step_last || ({1'b0, ptr} == count - CW'(1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDB_SEQ_IDLE;
            ptr   <= '0;
            count <= '0;
        end else begin
            case (state)
                IDB_SEQ_IDLE: begin
                    if (clear) begin
                        count <= '0;
                    end else begin
                        if (wr_en) count <= count + CW'(1);
                        // a write accepted alongside go joins the program
                        if (go && (count != '0 || wr_en)) begin
                            state <= IDB_SEQ_RUN;
                            ptr   <= '0;
                        end
                    end
                end
                IDB_SEQ_RUN: begin
                    if (rdy) begin
                        if (terminal) state <= IDB_SEQ_DONE;
                        else          ptr   <= ptr + AW'(1);
                    end
                end
                default: state <= IDB_SEQ_IDLE;
            endcase
        end
    end

    assign busy   = (state == IDB_SEQ_RUN);
    assign done   = (state == IDB_SEQ_DONE);
    assign cntl   = busy ? idb_src_onehot(step_src) : IDB_CNTL_IDLE;
    assign dst_ld = (busy && rdy) ? step_dst : '0;

endmodule

// File: tb/tb_idb_source_sequencer.sv
module tb_idb_source_sequencer;

    localparam int DEPTH = 8;
    localparam int DST_W = 6;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 0;
    logic             rst_n = 0;
    logic             ld_valid = 0, ld_last = 0, clear = 0, go = 0, rdy = 1;
    logic [2:0]       ld_src = 0;
    logic [DST_W-1:0] ld_dst = 0;
    logic             ld_ready, busy, done;
    logic [8:0]       cntl;
    logic [DST_W-1:0] dst_ld;
    logic [CW-1:0]    count;

    idb_source_sequencer #(.DEPTH(DEPTH), .DST_W(DST_W)) dut (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_ready(ld_ready),
        .ld_src(ld_src), .ld_dst(ld_dst), .ld_last(ld_last), .clear(clear),
        .go(go), .rdy(rdy), .cntl(cntl), .dst_ld(dst_ld), .busy(busy),
        .done(done), .count(count)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;

    // reference program: what has been accepted, in order
    logic [2:0]       m_src [DEPTH];
    logic [DST_W-1:0] m_dst [DEPTH];
    bit               m_last[DEPTH];
    int               m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // enter a new cycle with idle inputs; outputs are checked #1 later
    task automatic nxt();
        @(negedge clk);
        ld_valid = 0; clear = 0; go = 0; rdy = 1;
    endtask

    function automatic int plen();
        for (int i = 0; i < m_cnt; i++) if (m_last[i]) return i + 1;
        return m_cnt;
    endfunction

    task automatic accept(input logic [2:0] s, input logic [DST_W-1:0] d, input bit l);
        if (m_cnt < DEPTH) begin
            m_src[m_cnt] = s; m_dst[m_cnt] = d; m_last[m_cnt] = l; m_cnt++;
        end
    endtask

    task automatic load(input logic [2:0] s, input logic [DST_W-1:0] d, input bit l);
        nxt();
        ld_valid = 1; ld_src = s; ld_dst = d; ld_last = l;
        #1;
        chk("ld_ready", ld_ready, m_cnt < DEPTH);
        chk("count", count, m_cnt);
        accept(s, d, l);
    endtask

    // Expect playback starting next cycle. Step sstep stalls sn cycles;
    // other steps stall randomly (pct %, at most 3 in a row).
    task automatic expect_play(input int pct, input int sstep, input int sn);
        int n;
        n = plen();
        for (int i = 0; i < n; i++) begin
            int st;
            st = 0;
            while (1) begin
                nxt();
                if (i == sstep) rdy = (st >= sn);
                else            rdy = !(st < 3 && $urandom_range(99) < pct);
                // these must all be ignored outside IDLE
                clear = $urandom_range(1); go = $urandom_range(1);
                ld_valid = $urandom_range(1); ld_src = $urandom; ld_dst = $urandom;
                #1;
                chk("run_cntl", cntl, {23'b0, 9'h1 << m_src[i]});
                chk("run_dst_ld", dst_ld, rdy ? m_dst[i] : '0);
                chk("run_busy", busy, 1);
                chk("run_done", done, 0);
                chk("run_ld_ready", ld_ready, 0);
                if (rdy) break;
                st++;
            end
        end
        nxt();
        rdy = $urandom_range(1); clear = $urandom_range(1); go = $urandom_range(1);
        #1;
        chk("done_pulse", done, 1);
        chk("done_cntl", cntl, 0);
        chk("done_dst_ld", dst_ld, 0);
        chk("done_busy", busy, 0);
        nxt(); #1;
        chk("idle_done", done, 0);
        chk("idle_busy", busy, 0);
        chk("idle_cntl", cntl, 0);
        chk("idle_count", count, m_cnt);
        chk("idle_ld_ready", ld_ready, m_cnt < DEPTH);
    endtask

    task automatic start_go();
        nxt(); go = 1; #1;
        chk("pre_go_busy", busy, 0);
        chk("pre_go_cntl", cntl, 0);
    endtask

    task automatic do_clear(input bit with_write);
        nxt(); clear = 1; ld_valid = with_write; ld_src = $urandom; ld_dst = $urandom;
        m_cnt = 0;
        nxt(); #1;
        chk("clear_count", count, 0);
        chk("clear_ld_ready", ld_ready, 1);
    endtask

    initial begin
        // reset
        rst_n = 0;
        nxt(); nxt(); #1;
        chk("rst_cntl", cntl, 0);
        chk("rst_dst_ld", dst_ld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_ld_ready", ld_ready, 1);
        nxt(); rst_n = 1;

        // basic 3-step program, no stalls
        load(3'd2, 6'b000001, 0);
        load(3'd5, 6'b000100, 0);
        load(3'd7, 6'b100000, 1);
        start_go();
        expect_play(0, -1, 0);

        // same program, step 1 stalled two cycles
        start_go();
        expect_play(0, 1, 2);

        // fill to DEPTH, one extra write refused
        do_clear(0);
        for (int i = 0; i <= DEPTH; i++) load(3'($urandom), DST_W'($urandom), 0);
        nxt(); #1;
        chk("full_count", count, DEPTH);
        chk("full_ld_ready", ld_ready, 0);
        start_go();
        expect_play(0, -1, 0);

        // LAST on step 1 of 4, replayed twice
        do_clear(0);
        for (int i = 0; i < 4; i++) load(3'($urandom), DST_W'($urandom), i == 1);
        start_go();
        expect_play(0, -1, 0);
        start_go();
        expect_play(0, -1, 0);

        // GO with an empty program is ignored; CLEAR beats a write
        do_clear(1);
        nxt(); go = 1;
        nxt(); #1;
        chk("empty_go_busy", busy, 0);
        chk("empty_go_cntl", cntl, 0);
        nxt(); #1;
        chk("empty_go_done", done, 0);

        // randomized programs
        for (int r = 0; r < 40; r++) begin
            int nl;
            if ($urandom_range(2) == 0 || m_cnt == DEPTH) do_clear($urandom_range(1));
            nl = $urandom_range(DEPTH / 2 + 1, 0);
            for (int i = 0; i < nl; i++)
                load(3'($urandom), DST_W'($urandom), $urandom_range(5) == 0);
            if (m_cnt > 0 && m_cnt < DEPTH && $urandom_range(1)) begin
                logic [2:0] s; logic [DST_W-1:0] d; bit l;
                s = $urandom; d = $urandom; l = ($urandom_range(3) == 0);
                nxt(); go = 1; ld_valid = 1; ld_src = s; ld_dst = d; ld_last = l; #1;
                chk("go_ld_ready", ld_ready, 1);
                accept(s, d, l);
                expect_play(30, -1, 0);
            end else if (m_cnt > 0) begin
                start_go();
                expect_play(30, -1, 0);
            end
        end

        // reset during the second RUN cycle
        if (m_cnt == 0) load(3'd1, 6'b000011, 0);
        load(3'd4, 6'b010000, 0);
        load(3'd6, 6'b001000, 0);
        start_go();
        nxt(); #1;
        chk("pre_rst_busy", busy, 1);
        nxt(); rst_n = 0; #1;
        nxt(); rst_n = 1; #1;
        m_cnt = 0;
        chk("midrst_cntl", cntl, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_count", count, 0);
        chk("midrst_ld_ready", ld_ready, 1);
        chk("midrst_dst_ld", dst_ld, 0);

        // program works again after reset
        load(3'd3, 6'b000010, 0);
        load(3'd0, 6'b111111, 0);
        start_go();
        expect_play(0, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
